// File: rtl/cronometro_pkg.sv
// Shared types and helpers for the stopwatch control block.
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } crono_state_t;

  typedef logic [2:0] disp_sel_t;

  localparam disp_sel_t DISP_COUNT = 3'b000;
  localparam disp_sel_t DISP_LAP1  = 3'b001;
  localparam disp_sel_t DISP_LAP2  = 3'b010;
  localparam disp_sel_t DISP_LAP3  = 3'b100;

  localparam int unsigned N_LAPS = 3;

  function automatic logic [1:0] next_slot(input logic [1:0] slot);
    return (slot == 2'(N_LAPS - 1)) ? 2'b00 : slot + 2'b01;
  endfunction

  function automatic disp_sel_t next_disp(input disp_sel_t sel);
    case (sel)
      DISP_COUNT: return DISP_LAP1;
      DISP_LAP1:  return DISP_LAP2;
      DISP_LAP2:  return DISP_LAP3;
      default:    return DISP_COUNT;
    endcase
  endfunction

endpackage

// File: rtl/cronometro_controle_debounce.sv
// One button: 2-FF synchronizer, stability counter, debounced level and
// a one-cycle pulse on each debounced press (1 -> 0).
module cronometro_controle_debounce #(
  parameter int unsigned DB_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_prev;
  logic            r_press;
  logic [DB_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_prev  <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_level;
      r_press <= r_prev & ~r_level;
      // Level follows the synced input only after it disagrees long enough.
      if (r_sync2 != r_level) begin
        if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cronometro_controle.sv
// Stopwatch control: debounces the buttons, arbitrates presses and drives
// run/clear/lap-store/display-select towards the counter and lap datapath.
module cronometro_controle
  import cronometro_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       store,
  input  logic       disp_btn,
  output logic       run,
  output logic       clear,
  output logic       store_en,
  output logic [1:0] lap_slot,
  output logic [2:0] disp_lap,
  output logic [2:0] lap_valid,
  output logic [1:0] state
);

  logic w_start;
  logic w_pause;
  logic w_stop;
  logic w_store;
  logic w_disp;

  cronometro_controle_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .i_btn_n(start), .o_press(w_start));
  cronometro_controle_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk(clk), .rst(rst), .i_btn_n(pause), .o_press(w_pause));
  cronometro_controle_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk(clk), .rst(rst), .i_btn_n(stop), .o_press(w_stop));
  cronometro_controle_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_store (
    .clk(clk), .rst(rst), .i_btn_n(store), .o_press(w_store));
  cronometro_controle_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_disp (
    .clk(clk), .rst(rst), .i_btn_n(disp_btn), .o_press(w_disp));

  crono_state_t r_state;
  logic         r_run;
  logic         r_clear;
  logic         r_store_en;
  logic [1:0]   r_lap_slot;
  logic [1:0]   r_ptr;
  disp_sel_t    r_disp;
  logic [2:0]   r_lap_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_run       <= 1'b0;
      r_clear     <= 1'b0;
      r_store_en  <= 1'b0;
      r_lap_slot  <= 2'b00;
      r_ptr       <= 2'b00;
      r_disp      <= DISP_COUNT;
      r_lap_valid <= 3'b000;
    end else begin
      r_clear    <= 1'b0;
      r_store_en <= 1'b0;
      // Priority stop > pause > start > store; a losing press is dropped.
      if (w_stop) begin
        r_state     <= IDLE;
        r_run       <= 1'b0;
        r_clear     <= 1'b1;
        r_ptr       <= 2'b00;
        r_lap_valid <= 3'b000;
      end else if (w_pause) begin
        if (r_state == RUN) begin
          r_state <= PAUSE;
          r_run   <= 1'b0;
        end
      end else if (w_start) begin
        if (r_state != RUN) begin
          r_state <= RUN;
          r_run   <= 1'b1;
        end
      end else if (w_store && (r_state != IDLE)) begin
        r_store_en  <= 1'b1;
        r_lap_slot  <= r_ptr;
        r_lap_valid <= r_lap_valid | (3'b001 << r_ptr);
        r_ptr       <= next_slot(r_ptr);
      end
      if (w_disp) begin
        r_disp <= next_disp(r_disp);
      end
    end
  end

  assign run       = r_run;
  assign clear     = r_clear;
  assign store_en  = r_store_en;
  assign lap_slot  = r_lap_slot;
  assign disp_lap  = r_disp;
  assign lap_valid = r_lap_valid;
  assign state     = r_state;

endmodule

// File: tb/tb_cronometro_controle.sv
// Randomized bench for cronometro_controle against a cycle-level reference model.
module tb_cronometro_controle;

  localparam int unsigned DB = 2;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic       run, clear, store_en;
  logic [1:0] lap_slot, state;
  logic [2:0] disp_lap, lap_valid;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: 0 idle, 1 running, 2 paused.
  int         m_state, m_ptr, m_disp_idx;
  logic       m_clear, m_store_en;
  logic [1:0] m_slot;
  logic [2:0] m_valid;
  logic       m_level [5];
  int         m_run   [5];
  logic [4:0] m_q [$];

  cronometro_controle #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .start(btn[2]), .pause(btn[1]), .stop(btn[0]), .store(btn[3]), .disp_btn(btn[4]),
    .run(run), .clear(clear), .store_en(store_en), .lap_slot(lap_slot),
    .disp_lap(disp_lap), .lap_valid(lap_valid), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] disp_code(input int idx);
    logic [2:0] one;
    one = 3'b001;
    return (idx == 0) ? 3'b000 : 3'(one << (idx - 1));
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_disp_idx = 0;
    m_clear = 1'b0; m_store_en = 1'b0; m_slot = 2'b00; m_valid = 3'b000;
    for (int b = 0; b < 5; b++) begin
      m_level[b] = 1'b1;
      m_run[b]   = 0;
    end
    m_q.delete();
    repeat (LAT) m_q.push_back(5'b0);
  endtask

  // Presses detected on raw samples take effect LAT edges later.
  task automatic model_edge();
    logic [4:0] p;
    logic [4:0] f;
    p = m_q.pop_front();
    f = 5'b0;
    m_clear = 1'b0;
    m_store_en = 1'b0;
    if (p[0]) begin
      m_state = 0; m_clear = 1'b1; m_ptr = 0; m_valid = 3'b000;
    end else if (p[1]) begin
      if (m_state == 1) m_state = 2;
    end else if (p[2]) begin
      m_state = 1;
    end else if (p[3] && m_state != 0) begin
      m_store_en = 1'b1;
      m_slot = 2'(m_ptr);
      m_valid[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % 3;
    end
    if (p[4]) m_disp_idx = (m_disp_idx + 1) % 4;
    for (int b = 0; b < 5; b++) begin
      if (btn[b] != m_level[b]) begin
        m_run[b]++;
        if (m_run[b] == int'(DB)) begin
          m_level[b] = btn[b];
          m_run[b] = 0;
          if (!btn[b]) f[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_q.push_back(f);
  endtask

  function automatic logic [15:0] dut_pack();
    return {3'b0, state, run, clear, store_en, (store_en ? lap_slot : 2'b00), disp_lap, lap_valid};
  endfunction

  function automatic logic [15:0] model_pack();
    return {3'b0, 2'(m_state), (m_state == 1), m_clear, m_store_en,
            (m_store_en ? m_slot : 2'b00), disp_code(m_disp_idx), m_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    chk("cycle", dut_pack(), model_pack());
  endtask

  task automatic press(input int b, input int low, input int high);
    btn[b] = 1'b0;
    repeat (low) tick();
    btn[b] = 1'b1;
    repeat (high) tick();
  endtask

  int hold [5];

  initial begin
    btn = 5'h1f;
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("reset_outputs", dut_pack(), 16'h0000);
    rst = 1'b0;
    tick();

    // Start held 10 cycles.
    press(2, 10, 6);
    chk("t1_state", 16'(state), 16'h0001);
    chk("t1_run", 16'(run), 16'h0001);

    // One-cycle bounce on pause, then a real pause.
    press(1, 1, 8);
    chk("t2_bounce", 16'(state), 16'h0001);
    press(1, 6, 4);
    chk("t2_pause", 16'({state, run}), 16'(3'b100));

    press(2, 4, 4);
    for (int i = 0; i < 4; i++) press(3, 4, 4);
    chk("t3_valid", 16'(lap_valid), 16'h0007);

    // Stop and start together: stop wins.
    btn[0] = 1'b0; btn[2] = 1'b0;
    repeat (5) tick();
    btn[0] = 1'b1; btn[2] = 1'b1;
    repeat (4) tick();
    chk("t4_idle", 16'({state, run, lap_valid}), 16'h0000);

    for (int i = 0; i < 5; i++) press(4, 3, 3);
    chk("t5_disp", 16'(disp_lap), 16'h0001);
    press(0, 4, 4);
    chk("t5_disp_stop", 16'(disp_lap), 16'h0001);

    // Reset while store is mid-debounce.
    press(2, 4, 4);
    btn[3] = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("t6_async_rst", dut_pack(), 16'(disp_lap));
    chk("t6_disp_rst", 16'(disp_lap), 16'h0000);
    model_reset();
    btn = 5'h1f;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("t6_after", 16'({state, store_en}), 16'h0000);

    // Random button activity with occasional resets.
    for (int b = 0; b < 5; b++) hold[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold[b] == 0) begin
          btn[b]  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
          hold[b] = int'($urandom_range(1, 7));
        end
        hold[b]--;
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    btn = 5'h1f;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
